// File: rtl/pipeline_monitor_pkg.sv
// Shared register map, per-channel register offsets and channel FSM state type
// for the pipeline debug monitor.
package pipeline_monitor_pkg;

  localparam logic [7:0] REG_ID       = 8'h00;
  localparam logic [7:0] REG_CYC      = 8'h01;
  localparam logic [7:0] REG_STICKY   = 8'h02;
  localparam logic [7:0] REG_ERR      = 8'h03;
  localparam logic [7:0] REG_CH_BASE  = 8'h10;
  localparam logic [7:0] REG_CAP_BASE = 8'h40;
  localparam logic [7:0] REG_CAP_VLD  = 8'h60;

  localparam logic [1:0] OFF_START = 2'd0;
  localparam logic [1:0] OFF_DONE  = 2'd1;
  localparam logic [1:0] OFF_BUSY  = 2'd2;
  localparam logic [1:0] OFF_LAT   = 2'd3;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} ch_state_e;

endpackage

// File: rtl/monitor_channel.sv
// One monitored stage: start/done handshake FSM, saturating start/done/busy
// counters, last-op latency and sticky protocol-error flags.
module monitor_channel
  import pipeline_monitor_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             vld_i,
  input  logic             rdy_i,
  output logic [CNT_W-1:0] start_cnt_o,
  output logic [CNT_W-1:0] done_cnt_o,
  output logic [CNT_W-1:0] busy_cnt_o,
  output logic [CNT_W-1:0] last_lat_o,
  output logic             err_overlap_o,
  output logic             err_orphan_o
);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] start_q, start_d, done_q, done_d, busy_q, busy_d;
  logic [CNT_W-1:0] last_q, last_d, cur_q, cur_d;
  logic             ovl_q, ovl_d, orph_q, orph_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      state_q <= IDLE;
      start_q <= '0;
      done_q  <= '0;
      busy_q  <= '0;
      last_q  <= '0;
      cur_q   <= '0;
      ovl_q   <= 1'b0;
      orph_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      cur_q   <= cur_d;
      ovl_q   <= ovl_d;
      orph_q  <= orph_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (vld_i && !rdy_i) state_d = BUSY;
      BUSY: if (rdy_i && !vld_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // cur_q counts cycles since the accepted start; copied to last_q on done.
  always_comb begin
    start_d = start_q;
    done_d  = done_q;
    busy_d  = busy_q;
    last_d  = last_q;
    cur_d   = cur_q;
    ovl_d   = ovl_q;
    orph_d  = orph_q;
    case (state_q)
      IDLE: begin
        if (vld_i) begin
          start_d = sat_inc(start_q);
          if (rdy_i) begin
            done_d = sat_inc(done_q);
            last_d = '0;
          end else begin
            cur_d = CNT_W'(1);
          end
        end else if (rdy_i) begin
          orph_d = 1'b1;
        end
      end
      BUSY: begin
        busy_d = sat_inc(busy_q);
        if (rdy_i) begin
          done_d = sat_inc(done_q);
          last_d = cur_q;
          if (vld_i) begin
            start_d = sat_inc(start_q);
            cur_d   = CNT_W'(1);
          end
        end else begin
          cur_d = sat_inc(cur_q);
          if (vld_i) ovl_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign start_cnt_o   = start_q;
  assign done_cnt_o    = done_q;
  assign busy_cnt_o    = busy_q;
  assign last_lat_o    = last_q;
  assign err_overlap_o = ovl_q;
  assign err_orphan_o  = orph_q;

endmodule

// File: rtl/pipeline_monitor.sv
// Debug monitor top: per-stage channels, sticky flags, address-matched
// capture slots, free-running cycle counter and registered read port.
module pipeline_monitor
  import pipeline_monitor_pkg::*;
#(
  parameter int          NUM_CH   = 4,
  parameter int          CNT_W    = 32,
  parameter int          NUM_CAP  = 2,
  parameter int          ADDR_W   = 14,
  parameter int          DATA_W   = 12,
  parameter bit          CAP_LAST = 1'b0,
  parameter logic [31:0] ID_VALUE = 32'd19032003
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr_i,
  input  logic [NUM_CH-1:0]         vld_i,
  input  logic [NUM_CH-1:0]         rdy_i,
  input  logic                      cap_qual_i,
  input  logic [ADDR_W-1:0]         cap_addr_i,
  input  logic [DATA_W-1:0]         cap_data_i,
  input  logic [NUM_CAP*ADDR_W-1:0] cap_match_i,
  input  logic                      rd_en_i,
  input  logic [7:0]                rd_addr_i,
  output logic [31:0]               rd_data_o,
  output logic                      rd_vld_o,
  output logic [2*NUM_CH-1:0]       sticky_o
);

  localparam int CH_IW  = (NUM_CH  > 1) ? $clog2(NUM_CH)  : 1;
  localparam int CAP_IW = (NUM_CAP > 1) ? $clog2(NUM_CAP) : 1;

  logic [CNT_W-1:0]                  cyc_q;
  logic [NUM_CH-1:0]                 vseen_q, rseen_q, err_ovl, err_orph;
  logic [NUM_CH-1:0][CNT_W-1:0]      start_cnt, done_cnt, busy_cnt, last_lat;
  logic [NUM_CAP-1:0][DATA_W-1:0]    cap_q;
  logic [NUM_CAP-1:0]                cap_vld_q, cap_hit;
  logic [31:0]                       rd_data_q, rd_val;
  logic                              rd_vld_q;
  logic [5:0]                        ch_off;
  logic [CH_IW-1:0]                  ch_sel;
  logic [CAP_IW-1:0]                 cap_sel;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    monitor_channel #(.CNT_W(CNT_W)) u_ch (
      .clk           (clk),
      .rst           (rst),
      .clr_i         (clr_i),
      .vld_i         (vld_i[c]),
      .rdy_i         (rdy_i[c]),
      .start_cnt_o   (start_cnt[c]),
      .done_cnt_o    (done_cnt[c]),
      .busy_cnt_o    (busy_cnt[c]),
      .last_lat_o    (last_lat[c]),
      .err_overlap_o (err_ovl[c]),
      .err_orphan_o  (err_orph[c])
    );
  end

  for (genvar k = 0; k < NUM_CAP; k++) begin : g_hit
    assign cap_hit[k] = cap_qual_i && (cap_addr_i == cap_match_i[k*ADDR_W +: ADDR_W]);
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cyc_q     <= '0;
      vseen_q   <= '0;
      rseen_q   <= '0;
      cap_q     <= '0;
      cap_vld_q <= '0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      cyc_q     <= cyc_q + 1'b1;
      vseen_q   <= vseen_q | vld_i;
      rseen_q   <= rseen_q | rdy_i;
      cap_vld_q <= cap_vld_q | cap_hit;
      for (int k = 0; k < NUM_CAP; k++)
        if (cap_hit[k] && (CAP_LAST || !cap_vld_q[k])) cap_q[k] <= cap_data_i;
      rd_vld_q <= rd_en_i;
      if (rd_en_i) rd_data_q <= rd_val;
    end
  end

  // Channel window ends at the capture base; channels past 0x3F are unreachable.
  assign ch_off  = rd_addr_i[7:2] - 6'd4;
  assign ch_sel  = ch_off[CH_IW-1:0];
  assign cap_sel = rd_addr_i[CAP_IW-1:0];

  always_comb begin
    rd_val = '0;
    if (rd_addr_i == REG_ID) rd_val = ID_VALUE;
    else if (rd_addr_i == REG_CYC) rd_val = 32'(cyc_q);
    else if (rd_addr_i == REG_STICKY) rd_val = 32'({vseen_q, rseen_q});
    else if (rd_addr_i == REG_ERR) rd_val = 32'({err_ovl, err_orph});
    else if (rd_addr_i == REG_CAP_VLD) rd_val = 32'(cap_vld_q);
    else if (rd_addr_i >= REG_CH_BASE && rd_addr_i < REG_CAP_BASE) begin
      if (32'(ch_off) < NUM_CH) begin
        case (rd_addr_i[1:0])
          OFF_START: rd_val = 32'(start_cnt[ch_sel]);
          OFF_DONE:  rd_val = 32'(done_cnt[ch_sel]);
          OFF_BUSY:  rd_val = 32'(busy_cnt[ch_sel]);
          default:   rd_val = 32'(last_lat[ch_sel]);
        endcase
      end
    end else if (rd_addr_i >= REG_CAP_BASE && rd_addr_i < REG_CAP_BASE + 8'd16) begin
      if (32'(rd_addr_i[3:0]) < NUM_CAP) rd_val = 32'(cap_q[cap_sel]);
    end
  end

  assign rd_data_o = rd_data_q;
  assign rd_vld_o  = rd_vld_q;
  assign sticky_o  = {vseen_q, rseen_q};

endmodule

// File: tb/tb_pipeline_monitor.sv
// Checks two monitor configurations (32-bit/keep-first, 4-bit/keep-last) in
// lockstep against a timestamp-based model of the stage protocol.
module tb_pipeline_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1, clr = 1'b0;
  logic [3:0]  vld = '0, rdy = '0;
  logic        qual = 1'b0;
  logic [13:0] caddr = '0;
  logic [11:0] cdata = '0;
  logic [27:0] cmatch = {14'd20, 14'd10};
  logic        rd_en = 1'b0;
  logic [7:0]  rd_addr = '0;
  logic [31:0] rdata_a, rdata_b;
  logic        rvld_a, rvld_b;
  logic [7:0]  stk_a, stk_b;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  pipeline_monitor #(.CAP_LAST(1'b0)) dut_a (
    .clk(clk), .rst(rst), .clr_i(clr), .vld_i(vld), .rdy_i(rdy),
    .cap_qual_i(qual), .cap_addr_i(caddr), .cap_data_i(cdata), .cap_match_i(cmatch),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rdata_a), .rd_vld_o(rvld_a),
    .sticky_o(stk_a));

  pipeline_monitor #(.CNT_W(4), .CAP_LAST(1'b1)) dut_b (
    .clk(clk), .rst(rst), .clr_i(clr), .vld_i(vld), .rdy_i(rdy),
    .cap_qual_i(qual), .cap_addr_i(caddr), .cap_data_i(cdata), .cap_match_i(cmatch),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rdata_b), .rd_vld_o(rvld_b),
    .sticky_o(stk_b));

  // Model: unbounded counts and start timestamps; saturation applied on readout.
  longint now = 0, m_cyc = 0;
  longint m_start[4], m_done[4], m_busy[4], m_last[4], m_t0[4];
  bit     m_act[4], m_ovl[4], m_orph[4], m_vs[4], m_rs[4];
  bit     c_vld[2];
  logic [11:0] c_first[2], c_last[2];
  logic [31:0] prev_a = '0, prev_b = '0;

  function automatic longint sat(longint x, longint mx);
    return (x > mx) ? mx : x;
  endfunction

  function automatic logic [31:0] exp_reg(int d, int a);
    longint mx = (d == 1) ? 64'd15 : 64'hFFFF_FFFF;
    logic [31:0] r = '0;
    int c;
    if (a == 0) r = 32'd19032003;
    else if (a == 1) r = 32'(m_cyc % (mx + 1));
    else if (a == 2) for (int i = 0; i < 4; i++) begin r[i] = m_rs[i]; r[4+i] = m_vs[i]; end
    else if (a == 3) for (int i = 0; i < 4; i++) begin r[i] = m_orph[i]; r[4+i] = m_ovl[i]; end
    else if (a >= 16 && a < 32) begin
      c = (a - 16) / 4;
      case (a % 4)
        0: r = 32'(sat(m_start[c], mx));
        1: r = 32'(sat(m_done[c], mx));
        2: r = 32'(sat(m_busy[c], mx));
        default: r = 32'(sat(m_last[c], mx));
      endcase
    end else if (a == 64 || a == 65) begin
      if (c_vld[a-64]) r = 32'((d == 1) ? c_last[a-64] : c_first[a-64]);
    end else if (a == 96) begin r[0] = c_vld[0]; r[1] = c_vld[1]; end
    return r;
  endfunction

  function automatic void model_update();
    if (rst || clr) begin
      m_cyc = 0;
      for (int i = 0; i < 4; i++) begin
        m_start[i] = 0; m_done[i] = 0; m_busy[i] = 0; m_last[i] = 0; m_t0[i] = 0;
        m_act[i] = 0; m_ovl[i] = 0; m_orph[i] = 0; m_vs[i] = 0; m_rs[i] = 0;
      end
      for (int k = 0; k < 2; k++) begin c_vld[k] = 0; c_first[k] = '0; c_last[k] = '0; end
    end else begin
      m_cyc++;
      for (int i = 0; i < 4; i++) begin
        if (vld[i]) m_vs[i] = 1;
        if (rdy[i]) m_rs[i] = 1;
        if (!m_act[i]) begin
          if (vld[i]) begin
            m_start[i]++;
            if (rdy[i]) begin m_done[i]++; m_last[i] = 0; end
            else begin m_act[i] = 1; m_t0[i] = now; end
          end else if (rdy[i]) m_orph[i] = 1;
        end else begin
          m_busy[i]++;
          if (rdy[i]) begin
            m_done[i]++;
            m_last[i] = now - m_t0[i];
            if (vld[i]) begin m_start[i]++; m_t0[i] = now; end
            else m_act[i] = 0;
          end else if (vld[i]) m_ovl[i] = 1;
        end
      end
      for (int k = 0; k < 2; k++)
        if (qual && caddr == cmatch[k*14 +: 14]) begin
          if (!c_vld[k]) c_first[k] = cdata;
          c_vld[k] = 1;
          c_last[k] = cdata;
        end
    end
    now++;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock: predict read result from pre-edge model, advance model, compare.
  task automatic tick(string tag);
    logic [31:0] ea, eb;
    bit ev;
    ev = rd_en && !rst && !clr;
    if (ev) begin ea = exp_reg(0, int'(rd_addr)); eb = exp_reg(1, int'(rd_addr)); end
    else if (rst || clr) begin ea = '0; eb = '0; end
    else begin ea = prev_a; eb = prev_b; end
    @(posedge clk);
    model_update();
    #1;
    chk({tag, ".vld_a"}, 32'(rvld_a), 32'(ev));
    chk({tag, ".vld_b"}, 32'(rvld_b), 32'(ev));
    chk({tag, ".data_a"}, rdata_a, ea);
    chk({tag, ".data_b"}, rdata_b, eb);
    chk({tag, ".sticky_a"}, 32'(stk_a), exp_reg(0, 2));
    chk({tag, ".sticky_b"}, 32'(stk_b), exp_reg(1, 2));
    prev_a = ea; prev_b = eb;
  endtask

  task automatic pulse(string tag, logic [3:0] v, logic [3:0] r);
    vld = v; rdy = r;
    tick(tag);
    vld = '0; rdy = '0;
  endtask

  task automatic rd(string tag, int a);
    rd_en = 1'b1; rd_addr = 8'(a);
    tick(tag);
    rd_en = 1'b0;
  endtask

  int alist[$] = '{0, 1, 2, 3, 16, 17, 18, 19, 20, 21, 22, 23, 24, 25, 26, 27,
                   28, 29, 30, 31, 32, 63, 64, 65, 66, 96, 97, 5, 80};

  task automatic rd_all(string tag);
    foreach (alist[i]) rd(tag, alist[i]);
  endtask

  initial begin
    tick("rst0"); tick("rst1");
    rst = 1'b0;

    rd("id", 0);
    chk("id_const", rdata_a, 32'd19032003);
    rd("cyc0", 1);
    tick("gap"); tick("gap"); tick("gap");
    rd("cyc1", 1);

    pulse("ch0_v", 4'b0001, 4'b0000);
    repeat (4) tick("ch0_wait");
    pulse("ch0_r", 4'b0000, 4'b0001);
    rd("ch0_busy", 8'h12);
    chk("ch0_busy_const", rdata_a, 32'd5);
    rd("ch0_lat", 8'h13);
    chk("ch0_lat_const", rdata_a, 32'd5);
    chk("ch0_sticky_const", 32'(stk_a & 8'h11), 32'h11);

    pulse("ch1_vr", 4'b0010, 4'b0010);
    pulse("ch1_v", 4'b0010, 4'b0000);
    tick("ch1_w"); tick("ch1_w");
    pulse("ch1_vr2", 4'b0010, 4'b0010);
    tick("ch1_w");
    pulse("ch1_r", 4'b0000, 4'b0010);
    rd("ch1_lat", 8'h17);
    chk("ch1_lat_const", rdata_a, 32'd2);

    pulse("ch2_orph", 4'b0000, 4'b0100);
    pulse("ch2_v", 4'b0100, 4'b0000);
    tick("ch2_w"); tick("ch2_w");
    pulse("ch2_v2", 4'b0100, 4'b0000);
    pulse("ch2_r", 4'b0000, 4'b0100);
    rd("err", 3);
    chk("err_const", rdata_a & 32'h44, 32'h44);

    qual = 1'b1; caddr = 14'd10; cdata = 12'h0AB; tick("cap1");
    cdata = 12'h0CD; tick("cap2");
    qual = 1'b0;
    rd("cap0", 8'h40);
    chk("cap_first_const", rdata_a, 32'h0AB);
    chk("cap_last_const", rdata_b, 32'h0CD);
    rd("capv", 8'h60);

    repeat (20) pulse("sat", 4'b1000, 4'b1000);
    rd("sat_rd", 8'h1C);
    chk("sat_const_b", rdata_b, 32'd15);
    chk("sat_const_a", rdata_a, 32'd20);
    rd_all("pre_clr");

    clr = 1'b1; vld = 4'hF; tick("clr");
    clr = 1'b0; vld = '0;
    rd_all("post_clr");
    pulse("clr_idle", 4'b0000, 4'b0001);
    rd("clr_orph", 3);

    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 4; i++) begin
        vld[i] = ($urandom_range(0, 3) == 0);
        rdy[i] = ($urandom_range(0, 2) == 0);
      end
      clr   = ($urandom_range(0, 99) == 0);
      qual  = $urandom_range(0, 1) == 1;
      caddr = 14'($urandom_range(8, 22));
      cdata = 12'($urandom);
      rd_en = $urandom_range(0, 1) == 1;
      rd_addr = 8'(alist[$urandom_range(0, alist.size() - 1)]);
      tick("rand");
    end
    vld = '0; rdy = '0; clr = 1'b0; qual = 1'b0; rd_en = 1'b0;
    rd_all("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_monitor.md
Name: pipeline_monitor

Overview:
- Parametrised on-chip debug monitor for the GAT accelerator's processing stages (SPMM, DMVM, softmax, aggregation, extensible to NUM_CH).
- Per-stage sticky start/done flags, start/done counters, busy-cycle counts, last-op latency and protocol-error flags.
- NUM_CAP address-matched data-capture slots and a free-running cycle counter.
- All state is read through a registered address-mapped read port that feeds the board-level debug outputs.

Parameters:
NUM_CH, 4, number of monitored stages (1..16)
CNT_W, 32, width of every counter (1..32; values zero-extended to 32 on readout)
NUM_CAP, 2, number of capture slots (1..16)
ADDR_W, 14, width of capture match address
DATA_W, 12, width of captured data (<=32)
CAP_LAST, 0, 0 = slot keeps first hit, 1 = slot keeps most recent hit
ID_VALUE, 32'd19032003, constant returned at register 0x00

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
clr_i  in  1  synchronous soft clear of all statistics
vld_i  in  NUM_CH  per-stage start pulse
rdy_i  in  NUM_CH  per-stage done pulse
cap_qual_i  in  1  capture qualifier
cap_addr_i  in  ADDR_W  observed address
cap_data_i  in  DATA_W  observed data
cap_match_i  in  NUM_CAP*ADDR_W  per-slot match address, slot k at [k*ADDR_W +: ADDR_W]
rd_en_i  in  1  read strobe
rd_addr_i  in  8  register address
rd_data_o  out  32  read data
rd_vld_o  out  1  read data valid
sticky_o  out  2*NUM_CH  {vld_seen[NUM_CH-1:0], rdy_seen[NUM_CH-1:0]}

Behaviour:
- One clock, clk. Reset is synchronous and active-high (rst).
- rst or clr_i (sampled high) clears all state: counters, flags, captures, channel FSMs to IDLE, rd_data_o=0, rd_vld_o=0, sticky_o=0.
- clr_i wins over any same-cycle event. rst additionally cancels an in-flight read.
- Cycle counter: increments every cycle and wraps.
- Channel FSM (states IDLE, BUSY):
  - IDLE & vld: go to BUSY, start_cnt++, lat_cur<=1.
  - IDLE & vld & rdy: zero-latency op. start_cnt++, done_cnt++, last_lat<=0, stay IDLE.
  - IDLE & rdy & !vld: set err_orphan, no count.
  - BUSY & !rdy: lat_cur++ and busy_cnt++. Set err_overlap if vld.
  - BUSY & rdy: done_cnt++, busy_cnt++, last_lat<=lat_cur. Goes to IDLE, or if vld is also high stays BUSY with start_cnt++ and lat_cur<=1.
- Latency definition: vld at cycle t, rdy at cycle t+L gives last_lat = L.
- All per-channel counters saturate at 2^CNT_W-1; they do not wrap.
- Sticky flags set on any vld_i/rdy_i bit and are cleared only by rst/clr_i. sticky_o is registered, so a set flag is visible one cycle after the pulse.
- Capture slot k hits when cap_qual_i && cap_addr_i==cap_match_i[k]:
  - It latches cap_data_i and sets cap_vld[k].
  - CAP_LAST=0: later hits are ignored once cap_vld[k] is set. CAP_LAST=1: every hit overwrites.
  - Multiple slots may hit in the same cycle.
- Read port: rd_en_i at cycle t gives rd_data_o and rd_vld_o=1 at t+1. rd_vld_o=0 otherwise, and rd_data_o holds its last value.
- Register map:
  - 0x00: ID_VALUE
  - 0x01: cycle counter
  - 0x02: sticky_o, zero-extended
  - 0x03: {err_overlap, err_orphan} per channel, zero-extended
  - 0x10+4c: start_cnt for channel c (offsets 0..3 are start_cnt, done_cnt, busy_cnt, last_lat)
  - 0x40+k: capture slot k data, zero-extended
  - 0x60: cap_vld mask
  - Unmapped addresses or out-of-range c/k return 0.
- A read returns the value as it stood before the same-cycle update: registers sampled at t, not t+1.

Decomposition:
- Package pipeline_monitor_pkg: register-map address constants (REG_ID, REG_CYC, REG_STICKY, REG_ERR, REG_CH_BASE, REG_CAP_BASE, REG_CAP_VLD), per-channel offset constants, and the ch_state_e enum {IDLE, BUSY}.
- Sub-module monitor_channel, one instance per stage via generate. It owns the FSM, the four counters and the error flags.
- Capture slots and read mux stay in the top level.

Test Plan:
- rst then read 0x00, 0x01 twice -> 19032003; second cycle-count read exceeds the first by the number of cycles between the two rd_en_i strobes.
- ch0 vld at t=10, rdy at t=15 -> reg 0x10=1, 0x11=1, 0x12=5, 0x13=5; sticky_o bits 4 and 0 set.
- ch1 vld and rdy both high in IDLE, then vld at t=20 with rdy and vld both high at t=23 followed by rdy at t=25 -> start_cnt=3, done_cnt=3, last_lat=2, no error flags.
- ch2 rdy with no vld, then vld twice 3 cycles apart without rdy -> reg 0x03 shows err_orphan[2] and err_overlap[2] set.
- CAP_LAST=0, cap_match slot0=10: hits with data 0x0AB then 0x0CD -> reg 0x40=0x0AB, 0x60 bit0=1. Repeat with CAP_LAST=1 -> 0x0CD.
- CNT_W=4: 20 start/done pairs -> start_cnt reads 15. Assert clr_i in the same cycle as a vld pulse -> all reads 0, FSM IDLE.
